// File: rtl/bp_bht_pkg.sv
// ============================================================================
// Package : bp_bht_pkg
// Brief   : Opcodes, immediate decoders and table-write ops for bp_bht
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bp_bht_pkg;

    localparam logic [6:0] INST_TYPE_B = 7'b1100011;
    localparam logic [6:0] INST_JAL    = 7'b1101111;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [1:0] {
        WR_LOAD = 2'd0,
        WR_INC  = 2'd1,
        WR_DEC  = 2'd2
    } bht_wr_op_e;

    // B-imm = {imm[12], imm[11], imm[10:5], imm[4:1]} from inst[31|7|30:25|11:8]
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // J-imm = {imm[20], imm[19:12], imm[11], imm[10:1]} from inst[31|19:12|20|30:21]
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_bht_ram.sv
// ============================================================================
// Module : bp_bht_ram
// Brief  : ENTRIES x CTR_W counter table, async read, sync read-modify-write
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_bht_ram
    import bp_bht_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  bht_wr_op_e       wop_i,
    input  logic [CTR_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [CTR_W-1:0] rdata_o
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    logic [CTR_W-1:0] mem_q [ENTRIES];
    logic [CTR_W-1:0] wcur;
    logic [CTR_W-1:0] wnext;

    assign rdata_o = mem_q[raddr_i];

    // Saturating step is applied on the write side so training needs no extra read port
    always_comb begin
        wcur  = mem_q[waddr_i];
        wnext = wdata_i;
        case (wop_i)
            WR_INC:  wnext = (wcur == CTR_MAX) ? wcur : wcur + CTR_ONE;
            WR_DEC:  wnext = (wcur == '0)      ? wcur : wcur - CTR_ONE;
            default: wnext = wdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wnext;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_bht.sv
// ============================================================================
// Module : bp_bht
// Brief  : PC-indexed saturating-counter branch predictor for the fetch stage
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_bht
    import bp_bht_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       inst_addr_i,
    input  logic [2:0]        hold_flag_i,
    output logic              isbranch_o,
    output logic [31:0]       branch_addr_o,
    input  logic [1:0]        branch_taken_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_mispred_i,
    output logic              init_busy_o,
    output logic [PERF_W-1:0] pred_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WNT      = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
    logic [PERF_W-1:0] pred_cnt_q, pred_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [6:0]       opcode;
    logic             is_b;
    logic             is_jal;
    logic             hold;
    logic             in_init;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] ctr_rd;
    logic             b_taken;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    bht_wr_op_e       ram_wop;

    logic             unused_upd_pc;

    assign opcode   = inst_i[6:0];
    assign is_b     = (opcode == INST_TYPE_B);
    assign is_jal   = (opcode == INST_JAL);
    assign hold     = (hold_flag_i != 3'b000);
    assign in_init  = (state_q == ST_INIT);
    assign pred_idx = inst_addr_i[IDX_W+1:2];
    assign upd_idx  = upd_pc_i[IDX_W+1:2];

    assign unused_upd_pc = ^upd_pc_i;

    // Table contents are undefined until the sweep completes, so B-type reads are masked
    assign b_taken = !in_init && ctr_rd[CTR_W-1];

    assign isbranch_o = !hold && (is_jal || (is_b && b_taken));

    always_comb begin
        branch_addr_o = '0;
        if (is_b) begin
            branch_addr_o = inst_addr_i + imm_b(inst_i);
        end else if (is_jal) begin
            branch_addr_o = inst_addr_i + imm_j(inst_i);
        end
    end

    // Sweep owns the write port while active; resolutions arriving then are dropped
    assign ram_we    = in_init || branch_taken_i[1];
    assign ram_waddr = in_init ? sweep_idx_q : upd_idx;
    assign ram_wop   = in_init           ? WR_LOAD :
                       branch_taken_i[0] ? WR_INC  : WR_DEC;

    bp_bht_ram #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W)
    ) u_bht_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wop_i   (ram_wop),
        .wdata_i (WNT),
        .raddr_i (pred_idx),
        .rdata_o (ctr_rd)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            ST_INIT: begin
                sweep_idx_d = sweep_idx_q + IDX_ONE;
                if (sweep_idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    sweep_idx_d = '0;
                end
            end
            default: begin
                state_d     = state_q;
                sweep_idx_d = sweep_idx_q;
            end
        endcase
    end

    always_comb begin
        pred_cnt_d    = pred_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (is_b && !hold && (pred_cnt_q != PERF_MAX)) begin
            pred_cnt_d = pred_cnt_q + PERF_ONE;
        end
        if (branch_taken_i[1] && upd_mispred_i && (mispred_cnt_q != PERF_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            sweep_idx_q   <= '0;
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sweep_idx_q   <= sweep_idx_d;
            pred_cnt_q    <= pred_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign init_busy_o   = in_init;
    assign pred_cnt_o    = pred_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

`default_nettype wire
